uart_csr_bridge: RTL
====================

Name: uart_csr_bridge

Overview:
- Host-side initiator for the UART CSR access interface.
- Accepts read/write commands on a valid/ready request channel and drives exactly one CSR write or read strobe per command.
- Captures registered read data and returns it on a valid/ready response channel.
- Sits between a host (bus adapter or command decoder) and the UART CSR block. Guarantees single ren pulses, because reading UART_STATUS_0 clears its error flags.

Parameters:
- ADDR_W, default UART_CSR_ADDR_WIDTH: CSR address width.
- DATA_W, default UART_CSR_DATA_WIDTH: CSR data width.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  host command valid.
- req_ready  out  1  bridge can accept a command.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  CSR address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts response.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_error  out  1  command rejected: unmapped address or write to read-only register.
- csr_wr_addr  out  ADDR_W  to CSR wr_addr.
- csr_wr_data  out  DATA_W  to CSR wr_data.
- csr_wen  out  1  to CSR wen.
- csr_rd_addr  out  ADDR_W  to CSR rd_addr.
- csr_ren  out  1  to CSR ren.
- csr_rd_data  in  DATA_W  from CSR rd_data; registered, valid one cycle after ren.

Behaviour:
- Reset: state IDLE. All outputs 0, including req_ready, while rst_n is low. req_ready rises the first cycle after reset deassertion. Captured address, data and error registers are cleared.
- All outputs are registered.
- IDLE:
  - req_ready=1. A command is accepted on req_valid && req_ready; it is cycle 0.
  - Address and data are captured. req_ready drops the following cycle.
- Address legality:
  - Legal reads: UART_BAUD_RATE_CSR_ADDR, UART_CONTROL_0_CSR_ADDR, UART_STATUS_0_CSR_ADDR.
  - Legal writes: BAUD_RATE and CONTROL_0 only.
  - Anything else goes to RSP with rsp_error=1 and rsp_rdata=0. No wen or ren is ever issued for it.
- WR: csr_wen=1 for exactly cycle 1, with csr_wr_addr/csr_wr_data stable. Next state is RSP (see macro).
- RD: csr_ren=1 for exactly cycle 1, with csr_rd_addr stable. Next state is RD_WAIT.
- RD_WAIT (cycle 2): csr_rd_data is sampled into rsp_rdata. Next state is RSP.
- RSP:
  - rsp_valid=1; rsp_rdata and rsp_error are held stable until rsp_valid && rsp_ready.
  - Then return to IDLE, and req_ready=1 in the next cycle.
  - rsp_ready high in the first RSP cycle completes the response in that cycle.
- Latency:
  - Legal read: rsp_valid in cycle 3.
  - Write, or any rejected command: rsp_valid in cycle 2.
  - Minimum command spacing is 4 cycles for reads and 3 cycles for writes.
- Never more than one outstanding command. csr_wen and csr_ren are never high in the same cycle.
- Backpressure: rsp_ready held low keeps the bridge in RSP indefinitely. No new CSR strobe is issued.
- Reset mid-operation (any state): return to IDLE, all strobes 0, any pending response discarded.
- Request inputs are ignored whenever req_ready=0. The host must hold them stable only until the handshake.

Optional Feature:
- Macro: UART_CSR_BRIDGE_WR_RSP_EN.
- Defined: every command, write or read, legal or illegal, produces exactly one response as described above.
- Undefined:
  - A legal write goes from WR straight to IDLE (req_ready=1 in cycle 2) with no response.
  - An illegal write is dropped silently with no response.
  - Reads are unchanged, including the error response for unmapped read addresses.

Decomposition:
- UART_pkg additions:
  - uart_csr_bridge_state_t enum: IDLE, WR, RD, RD_WAIT, RSP.
  - Function uart_csr_rd_legal(addr).
  - Function uart_csr_wr_legal(addr).
- Existing package types and constants are reused: uart_csr_addr_t, uart_csr_data_t, address constants, width constants.
- No sub-module: a single FSM plus capture registers.

Test Plan:
- Reset, then write 0x0000_1B58 to BAUD_RATE with rsp_ready=1 -> csr_wen high exactly in cycle 1 with that addr/data; rsp_valid in cycle 2 with rsp_error=0 and rsp_rdata=0 (macro defined).
- Read STATUS_0 with csr_rd_data model returning 0x5 one cycle after ren -> exactly one ren pulse; rsp_rdata=0x5 in cycle 3; rsp_error=0.
- Write to STATUS_0 -> no wen; rsp_error=1 in cycle 2. Read an unmapped address -> no ren; rsp_error=1; rsp_rdata=0.
- Read CONTROL_0 with rsp_ready held low for 10 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, no further strobes; completes on the cycle rsp_ready rises.
- Assert rst_n=0 in cycle 1 of a read (ren high) -> next cycle all outputs 0; first post-reset command behaves normally with no stale response.
- Macro undefined: back-to-back legal writes -> second accepted in cycle 2, no rsp_valid ever asserted; an illegal write produces no wen and no response.

Source files
------------

// File: rtl/uart_csr_bridge_pkg.sv
// UART CSR bridge package: CSR widths, address map, bridge FSM states and
// address-legality helpers shared by the bridge and its users.
// Latency: n/a (types and pure functions only). Backpressure: n/a.
package uart_csr_bridge_pkg;

  localparam int UART_CSR_ADDR_WIDTH = 8;
  localparam int UART_CSR_DATA_WIDTH = 32;

  typedef logic [UART_CSR_ADDR_WIDTH-1:0] uart_csr_addr_t;
  typedef logic [UART_CSR_DATA_WIDTH-1:0] uart_csr_data_t;

  localparam uart_csr_addr_t UART_BAUD_RATE_CSR_ADDR = 8'h00;
  localparam uart_csr_addr_t UART_CONTROL_0_CSR_ADDR = 8'h04;
  localparam uart_csr_addr_t UART_STATUS_0_CSR_ADDR  = 8'h08;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD      = 3'd2,
    RD_WAIT = 3'd3,
    RSP     = 3'd4
  } uart_csr_bridge_state_t;

  // All three mapped registers are readable.
  function automatic logic uart_csr_rd_legal(input uart_csr_addr_t addr);
    return (addr == UART_BAUD_RATE_CSR_ADDR) ||
           (addr == UART_CONTROL_0_CSR_ADDR) ||
           (addr == UART_STATUS_0_CSR_ADDR);
  endfunction

  // STATUS_0 is read-only, so only BAUD_RATE and CONTROL_0 take writes.
  function automatic logic uart_csr_wr_legal(input uart_csr_addr_t addr);
    return (addr == UART_BAUD_RATE_CSR_ADDR) ||
           (addr == UART_CONTROL_0_CSR_ADDR);
  endfunction

endpackage

// File: rtl/uart_csr_bridge.sv
// Host-side initiator: turns one valid/ready command into exactly one CSR wen/ren strobe.
// Latency: strobe in cycle 1; response in cycle 2 (write/rejected) or cycle 3 (legal read).
// Backpressure: one command outstanding; rsp_ready low holds RSP and blocks new commands.
//
// Ports: clk/rst_n (sync, active-low); req_* command channel (valid/ready);
//   rsp_* response channel (valid/ready, rdata + error); csr_* strobes, address
//   and data toward the UART CSR block, csr_rd_data registered one cycle after ren.
// Build option: UART_CSR_BRIDGE_WR_RSP_EN -- when defined, writes also return a
//   response; when undefined, legal writes finish silently and illegal writes are dropped.
module uart_csr_bridge
  import uart_csr_bridge_pkg::*;
#(
  parameter int ADDR_W = UART_CSR_ADDR_WIDTH,
  parameter int DATA_W = UART_CSR_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] csr_wr_addr,
  output logic [DATA_W-1:0] csr_wr_data,
  output logic              csr_wen,
  output logic [ADDR_W-1:0] csr_rd_addr,
  output logic              csr_ren,
  input  logic [DATA_W-1:0] csr_rd_data
);

`ifdef UART_CSR_BRIDGE_WR_RSP_EN
  localparam bit WR_RSP = 1'b1;
`else
  localparam bit WR_RSP = 1'b0;
`endif

  uart_csr_bridge_state_t state;
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic                   write_q;
  logic                   err_q;
  logic                   accept;
  logic                   legal;

  assign accept = req_valid && req_ready;
  assign legal  = req_write ? uart_csr_wr_legal(uart_csr_addr_t'(req_addr))
                            : uart_csr_rd_legal(uart_csr_addr_t'(req_addr));

  // One captured address feeds both CSR ports; only the strobe says which is live.
  assign csr_wr_addr = addr_q;
  assign csr_rd_addr = addr_q;
  assign csr_wr_data = wdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      csr_wen   <= 1'b0;
      csr_ren   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // Strobes are single-cycle pulses by construction.
      csr_wen <= 1'b0;
      csr_ren <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            write_q   <= req_write;
            err_q     <= !legal;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            if (legal && !req_write) begin
              state   <= RD;
              csr_ren <= 1'b1;
            end else begin
              // Rejected commands also pass through WR (without a strobe) so
              // their response lands in cycle 2, same as a legal write.
              state   <= WR;
              csr_wen <= legal;
            end
          end
        end
        WR: begin
          // Rejected reads always answer; writes answer only when enabled.
          if (WR_RSP || !write_q) begin
            state     <= RSP;
            rsp_valid <= 1'b1;
            rsp_error <= err_q;
          end else begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
        RD: begin
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          // CSR read data is registered, so it is valid in this cycle only.
          rsp_rdata <= csr_rd_data;
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
